frame_buf_sched: RTL and testbench

Frame-buffer scheduler for the VDMA base-address path. It shares a ring of 3–5 frame buffers between the write channel (S2MM) and the read channel (MM2S). Each channel requests a buffer at frame start and receives a buffer index plus base address. The write side always receives the lowest-index free buffer. The read side always receives the newest completed frame, so a reader can never tear a frame being written.

---
 rtl/vdma_pkg.sv | 14 +
 rtl/buf_pick_lowest.sv | 22 ++
 rtl/frame_buf_sched.sv | 169 ++++++++++++++++
 tb/tb_frame_buf_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vdma_pkg.sv
// Shared VDMA definitions: buffer-state encodings, ring size limit and index width.
package vdma_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2,
    READING = 2'd3
  } buf_state_t;

  localparam int MAX_BUF = 5;
  localparam int IDX_W   = 3;

endpackage

// File: rtl/buf_pick_lowest.sv
// Lowest-set-bit finder over a candidate buffer mask.
module buf_pick_lowest
  import vdma_pkg::*;
(
  input  logic [MAX_BUF-1:0] mask,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = MAX_BUF - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_buf_sched.sv
// Frame-buffer scheduler: shares a 3..5 buffer ring between the VDMA write and
// read channels. Writer gets the lowest free buffer, reader gets the newest
// completed frame. Same-cycle events resolve as wr_done, then wr_req, then rd_req.
// Build option: define FRAME_DROP_CNT_EN to include the dropped-frame counter;
// otherwise drop_cnt is tied to zero.
module frame_buf_sched
  import vdma_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                BUF_NUM    = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = 32'h0080_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_req,
  input  logic              wr_done,
  output logic              wr_grant,
  output logic [2:0]        wr_idx,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_req,
  output logic              rd_grant,
  output logic [2:0]        rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_repeat,
  output logic              rd_none,
  output logic [7:0]        wr_abort_cnt,
  output logic [15:0]       drop_cnt
);

  buf_state_t st_q  [MAX_BUF];
  buf_state_t st_s1 [MAX_BUF];
  buf_state_t st_d  [MAX_BUF];

  logic              w_hit, r_hit, wr_abort;
  logic [IDX_W-1:0]  w_at, r_at;
  logic [MAX_BUF-1:0] free_mask;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              rdy_hit, rdg_hit;
  logic [IDX_W-1:0]  rdy_at, rdg_at;
  logic [IDX_W-1:0]  rd_idx_d;
  logic              rd_rep_d, rd_none_d;

  function automatic logic [ADDR_W-1:0] buf_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * BUF_STRIDE;
  endfunction

  // Write-side completion and abort, then the free mask the writer picks from.
  always_comb begin
    st_s1    = st_q;
    wr_abort = 1'b0;
    w_hit    = 1'b0;
    w_at     = '0;
    r_hit    = 1'b0;
    r_at     = '0;
    for (int i = 0; i < MAX_BUF; i++) begin
      if (st_q[i] == WRITING) begin
        w_hit = 1'b1;
        w_at  = IDX_W'(i);
      end
      if (st_q[i] == READY) begin
        r_hit = 1'b1;
        r_at  = IDX_W'(i);
      end
    end
    if (wr_done && w_hit) begin
      if (r_hit) st_s1[r_at] = FREE;
      st_s1[w_at] = READY;
    end else if (wr_req && w_hit) begin
      st_s1[w_at] = FREE;
      wr_abort    = 1'b1;
    end
    free_mask = '0;
    for (int i = 0; i < MAX_BUF; i++) begin
      free_mask[i] = (i < BUF_NUM) && (st_s1[i] == FREE);
    end
  end

  buf_pick_lowest u_pick (
    .mask  (free_mask),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Write grant claims the picked buffer; read grant takes READY or re-grants READING.
  always_comb begin
    st_d      = st_s1;
    rdy_hit   = 1'b0;
    rdy_at    = '0;
    rdg_hit   = 1'b0;
    rdg_at    = '0;
    rd_idx_d  = '0;
    rd_rep_d  = 1'b0;
    rd_none_d = 1'b0;
    for (int i = 0; i < MAX_BUF; i++) begin
      if (st_s1[i] == READY) begin
        rdy_hit = 1'b1;
        rdy_at  = IDX_W'(i);
      end
      if (st_s1[i] == READING) begin
        rdg_hit = 1'b1;
        rdg_at  = IDX_W'(i);
      end
    end
    if (wr_req && pick_found) st_d[pick_idx] = WRITING;
    if (rdy_hit) begin
      rd_idx_d = rdy_at;
      if (rd_req) begin
        if (rdg_hit) st_d[rdg_at] = FREE;
        st_d[rdy_at] = READING;
      end
    end else if (rdg_hit) begin
      rd_idx_d = rdg_at;
      rd_rep_d = 1'b1;
    end else begin
      rd_none_d = 1'b1;
    end
  end

  // Buffer states, registered grants and the abort counter.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < MAX_BUF; i++) st_q[i] <= FREE;
      wr_grant     <= 1'b0;
      wr_idx       <= '0;
      wr_addr      <= '0;
      rd_grant     <= 1'b0;
      rd_idx       <= '0;
      rd_addr      <= '0;
      rd_repeat    <= 1'b0;
      rd_none      <= 1'b1;
      wr_abort_cnt <= '0;
    end else begin
      st_q     <= st_d;
      wr_grant <= wr_req && pick_found;
      rd_grant <= rd_req;
      if (wr_req && pick_found) begin
        wr_idx  <= pick_idx;
        wr_addr <= buf_addr(pick_idx);
      end
      if (rd_req) begin
        rd_idx    <= rd_idx_d;
        rd_addr   <= buf_addr(rd_idx_d);
        rd_repeat <= rd_rep_d;
        rd_none   <= rd_none_d;
      end
      if (wr_abort && (wr_abort_cnt != 8'hFF)) wr_abort_cnt <= wr_abort_cnt + 8'd1;
    end
  end

`ifdef FRAME_DROP_CNT_EN
  logic drop_evt;
  assign drop_evt = wr_done && w_hit && r_hit;

  // Counts READY frames displaced by a newer completion before any read.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      drop_cnt <= '0;
    end else if (drop_evt && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_buf_sched.sv
// Self-checking bench for frame_buf_sched (BUF_NUM=3, base 0x1000_0000,
// stride 0x0080_0000). Expected grants are queued when requests are driven and
// checked when the grant cycle comes around.
module tb_frame_buf_sched;

  localparam int          ADDR_W = 32;
  localparam int          NBUF   = 3;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] STRIDE = 32'h0080_0000;

  logic              clk = 1'b0;
  logic              rst, clear, wr_req, wr_done, rd_req;
  logic              wr_grant, rd_grant, rd_repeat, rd_none;
  logic [2:0]        wr_idx, rd_idx;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [7:0]        wr_abort_cnt;
  logic [15:0]       drop_cnt;

  frame_buf_sched #(
    .ADDR_W(ADDR_W), .BUF_NUM(NBUF), .BASE_ADDR(BASE), .BUF_STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_req(wr_req), .wr_done(wr_done), .wr_grant(wr_grant),
    .wr_idx(wr_idx), .wr_addr(wr_addr),
    .rd_req(rd_req), .rd_grant(rd_grant), .rd_idx(rd_idx), .rd_addr(rd_addr),
    .rd_repeat(rd_repeat), .rd_none(rd_none),
    .wr_abort_cnt(wr_abort_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; bit rep; bit none;} rd_exp_t;

  int      wq_exp[$];
  rd_exp_t rq_exp[$];
  int      n_vec = 0;
  int      n_err = 0;

  // Reference model: -1 means "no buffer in that role".
  int m_w, m_rdy, m_rdg, m_abort, m_drop;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int idx);
    logic [31:0] a;
    a = BASE;
    for (int k = 0; k < idx; k++) a = a + STRIDE;
    return a;
  endfunction

  task automatic model_reset();
    m_w = -1; m_rdy = -1; m_rdg = -1; m_abort = 0; m_drop = 0;
    wq_exp.delete();
    rq_exp.delete();
  endtask

  task automatic model_step(input bit wd, input bit wq, input bit rq);
    rd_exp_t e;
    if (wd && m_w >= 0) begin
      if (m_rdy >= 0 && m_drop < 65535) m_drop++;
      m_rdy = m_w;
      m_w   = -1;
    end
    if (wq) begin
      if (m_w >= 0) begin
        if (m_abort < 255) m_abort++;
        m_w = -1;
      end
      for (int i = 0; i < NBUF; i++) begin
        if (i != m_rdy && i != m_rdg) begin
          m_w = i;
          break;
        end
      end
      wq_exp.push_back(m_w);
    end
    if (rq) begin
      e.rep = 0; e.none = 0; e.idx = 0;
      if (m_rdy >= 0) begin
        m_rdg = m_rdy;
        m_rdy = -1;
        e.idx = m_rdg;
      end else if (m_rdg >= 0) begin
        e.idx = m_rdg;
        e.rep = 1;
      end else begin
        e.none = 1;
      end
      rq_exp.push_back(e);
    end
  endtask

  // One clock: drive pulses, advance the model, then score the grant cycle.
  task automatic step(input bit wd, input bit wq, input bit rq, input bit cl);
    int      we;
    rd_exp_t re;
    int      exp_drop;
    @(negedge clk);
    wr_done = wd; wr_req = wq; rd_req = rq; clear = cl;
    if (cl) model_reset();
    else    model_step(wd, wq, rq);
    @(posedge clk);
    #1;
    wr_done = 0; wr_req = 0; rd_req = 0; clear = 0;
    chk("wr_grant", wr_grant, wq_exp.size() > 0);
    if (wr_grant && wq_exp.size() > 0) begin
      we = wq_exp.pop_front();
      chk("wr_idx", wr_idx, we);
      chk("wr_addr", wr_addr, exp_addr(we));
    end
    wq_exp.delete();
    chk("rd_grant", rd_grant, rq_exp.size() > 0);
    if (rd_grant && rq_exp.size() > 0) begin
      re = rq_exp.pop_front();
      chk("rd_idx", rd_idx, re.idx);
      chk("rd_repeat", rd_repeat, re.rep);
      chk("rd_none", rd_none, re.none);
      if (!re.none) chk("rd_addr", rd_addr, exp_addr(re.idx));
    end
    rq_exp.delete();
`ifdef FRAME_DROP_CNT_EN
    exp_drop = m_drop;
`else
    exp_drop = 0;
`endif
    chk("wr_abort_cnt", wr_abort_cnt, m_abort);
    chk("drop_cnt", drop_cnt, exp_drop);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd_none"}, rd_none, 1);
    chk({tag, "_rd_idx"}, rd_idx, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_idx"}, wr_idx, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_abort"}, wr_abort_cnt, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
  endtask

  initial begin
    rst = 1; clear = 0; wr_req = 0; wr_done = 0; rd_req = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_grant", wr_grant, 0);
    chk("rst_rd_grant", rd_grant, 0);
    chk_idle("rst");
    @(negedge clk);
    rst = 0;

    // Read before any frame exists.
    step(0, 0, 1, 0);
    // First write grant, completion, second write grant.
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    // Second frame completes unread: first frame dropped; reader gets newest.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    // Repeat read, then completion and read in the same cycle.
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(1, 0, 1, 0);
    // Writer aborts an open frame.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    // Clear mid-frame with a buffer WRITING and one READING.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk_idle("clr");
    // Abort right after clear: reuse of buffer 0.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    // Back-to-back and mixed traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 150) == 0));
    end
    // Drive the abort counter into saturation.
    for (int n = 0; n < 262; n++) step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    step(0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
